// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing -- raster timing generator for the screensaver display path.
//
// Produces the current raster coordinates, a one-pixel lookahead (NEXT) of
// those coordinates, a completed-frame counter and registered sync/visible
// strobes. A downstream stage that registers colour from the NEXT
// coordinates gets that colour valid in the same cycle as position_x/_y,
// hsync, vsync and visible.
//
// Ports:
//   clk              in   pixel clock
//   rst_n            in   asynchronous active-low reset
//   pixel_ce         in   pixel clock enable (only with VGA_TIMING_PIXEL_CE_EN)
//   position_x       out  [9:0]  current horizontal count
//   position_x_NEXT  out  [9:0]  horizontal count one pixel ahead
//   position_y       out  [8:0]  current vertical count, low 9 bits
//   position_y_NEXT  out  [8:0]  vertical count one pixel ahead, low 9 bits
//   frame            out  [31:0] completed-frame counter (wraps mod 2^32)
//   frame_start      out  high for the single cycle at position (0,0)
//   visible          out  current position lies in the active area
//   hsync, vsync     out  sync pulses, polarity set by HSYNC_POL/VSYNC_POL
//
// Optional build macro: VGA_TIMING_PIXEL_CE_EN
//   Defined   -> adds pixel_ce; all state advances only when pixel_ce = 1.
//   Undefined -> the raster advances on every clk edge.
// -----------------------------------------------------------------------------
module vga_timing #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_TIMING_PIXEL_CE_EN
    input  logic        pixel_ce,
`endif
    output logic [9:0]  position_x,
    output logic [9:0]  position_x_NEXT,
    output logic [8:0]  position_y,
    output logic [8:0]  position_y_NEXT,
    output logic [31:0] frame,
    output logic        frame_start,
    output logic        visible,
    output logic        hsync,
    output logic        vsync
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic        step;

`ifdef VGA_TIMING_PIXEL_CE_EN
    assign step = pixel_ce;
`else
    assign step = 1'b1;
`endif

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [31:0] frame_q, frame_d;
    logic        visible_q, visible_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;

    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic        h_wrap;
    logic        frame_wrap;

    // Lookahead position: always derived from the held state, so with the
    // clock enable low it still shows where the raster will go next.
    always_comb begin
        h_wrap     = (h_cnt_q == H_LAST);
        frame_wrap = h_wrap && (v_cnt_q == V_LAST);
        h_next     = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_next     = v_cnt_q;
        if (h_wrap) begin
            v_next = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Strobes are decoded from the NEXT position so that, once registered,
    // they line up with the counters they describe.
    always_comb begin
        h_cnt_d       = h_cnt_q;
        v_cnt_d       = v_cnt_q;
        frame_d       = frame_q;
        visible_d     = visible_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        frame_start_d = frame_start_q;
        if (step) begin
            h_cnt_d       = h_next;
            v_cnt_d       = v_next;
            frame_d       = frame_wrap ? frame_q + 32'd1 : frame_q;
            visible_d     = (h_next < H_ACT) && (v_next < V_ACT);
            hsync_d       = ((h_next >= HS_START) && (h_next < HS_END))
                            ? HSYNC_POL : ~HSYNC_POL;
            vsync_d       = ((v_next >= VS_START) && (v_next < VS_END))
                            ? VSYNC_POL : ~VSYNC_POL;
            frame_start_d = (h_next == 10'd0) && (v_next == 10'd0);
        end
    end

    // Reset state corresponds to position (0,0): inside the active area and
    // at the start of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            frame_q       <= 32'd0;
            visible_q     <= 1'b1;
            hsync_q       <= ~HSYNC_POL;
            vsync_q       <= ~VSYNC_POL;
            frame_start_q <= 1'b1;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            frame_q       <= frame_d;
            visible_q     <= visible_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
        end
    end

    // y is deliberately truncated to 9 bits; it is only meaningful while
    // visible is high.
    assign position_x      = h_cnt_q;
    assign position_x_NEXT = h_next;
    assign position_y      = v_cnt_q[8:0];
    assign position_y_NEXT = v_next[8:0];
    assign frame           = frame_q;
    assign frame_start     = frame_start_q;
    assign visible         = visible_q;
    assign hsync           = hsync_q;
    assign vsync           = vsync_q;

endmodule

// File: tb/tb_vga_timing.sv
// -----------------------------------------------------------------------------
// tb_vga_timing -- directed bench for vga_timing.
//
// dut_full uses the default 640x480 timing and checks line timing.
// dut_small keeps the full vertical timing but a 16-pixel line, so whole
// frames (8400 cycles) fit in a short run.
// -----------------------------------------------------------------------------
module tb_vga_timing;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
`ifdef VGA_TIMING_PIXEL_CE_EN
    logic        pixel_ce = 1'b1;
`endif

    logic [9:0]  f_x, f_xn, s_x, s_xn;
    logic [8:0]  f_y, f_yn, s_y, s_yn;
    logic [31:0] f_frame, s_frame;
    logic        f_fs, f_vis, f_hs, f_vs;
    logic        s_fs, s_vis, s_hs, s_vs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    vga_timing dut_full (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef VGA_TIMING_PIXEL_CE_EN
        .pixel_ce        (pixel_ce),
`endif
        .position_x      (f_x),
        .position_x_NEXT (f_xn),
        .position_y      (f_y),
        .position_y_NEXT (f_yn),
        .frame           (f_frame),
        .frame_start     (f_fs),
        .visible         (f_vis),
        .hsync           (f_hs),
        .vsync           (f_vs)
    );

    vga_timing #(
        .H_ACTIVE (8),
        .H_FRONT  (2),
        .H_SYNC   (3),
        .H_BACK   (3)
    ) dut_small (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef VGA_TIMING_PIXEL_CE_EN
        .pixel_ce        (pixel_ce),
`endif
        .position_x      (s_x),
        .position_x_NEXT (s_xn),
        .position_y      (s_y),
        .position_y_NEXT (s_yn),
        .frame           (s_frame),
        .frame_start     (s_fs),
        .visible         (s_vis),
        .hsync           (s_hs),
        .vsync           (s_vs)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string when);
        check({when, " full x"},      32'(f_x),     32'd0);
        check({when, " full y"},      32'(f_y),     32'd0);
        check({when, " full x_next"}, 32'(f_xn),    32'd1);
        check({when, " full y_next"}, 32'(f_yn),    32'd0);
        check({when, " full frame"},  f_frame,      32'd0);
        check({when, " full vis"},    32'(f_vis),   32'd1);
        check({when, " full fs"},     32'(f_fs),    32'd1);
        check({when, " full hs"},     32'(f_hs),    32'd1);
        check({when, " full vs"},     32'(f_vs),    32'd1);
        check({when, " small x"},     32'(s_x),     32'd0);
        check({when, " small y"},     32'(s_y),     32'd0);
        check({when, " small frame"}, s_frame,      32'd0);
        check({when, " small fs"},    32'(s_fs),    32'd1);
    endtask

    initial begin
        int fx, fy, sx, sy, sy1;
        int hs_low_cnt;
        int vs_low_cnt;
        logic [31:0] s_frame_exp;

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("step reset: holding rst_n low");
        check_reset_values("reset");
        rst_n = 1'b1;

        // ---------------- line / frame / wrap run ----------------
        hs_low_cnt  = 0;
        vs_low_cnt  = 0;
        s_frame_exp = 32'd0;
        for (int c = 1; c <= 16801; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c <= 1700) begin
                fx = c % 800;
                fy = c / 800;
                check("full x", 32'(f_x), 32'(fx));
                check("full y", 32'(f_y), 32'(fy));
                check("full x_next", 32'(f_xn), 32'((c + 1) % 800));
                check("full y_next", 32'(f_yn), 32'((c + 1) / 800));
                check("full hsync", 32'(f_hs), (fx >= 656 && fx <= 751) ? 32'd0 : 32'd1);
                check("full visible", 32'(f_vis), (fx < 640) ? 32'd1 : 32'd0);
                check("full frame_start", 32'(f_fs), 32'd0);
                if (c <= 800 && f_hs == 1'b0) hs_low_cnt++;
            end
            sx  = c % 16;
            sy  = (c / 16) % 525;
            sy1 = ((c + 1) / 16) % 525;
            if (c == 8400 || c == 16800) s_frame_exp = s_frame_exp + 32'd1;
            check("small x", 32'(s_x), 32'(sx));
            check("small y", 32'(s_y), 32'(sy % 512));
            check("small y_next", 32'(s_yn), 32'(sy1 % 512));
            check("small hsync", 32'(s_hs), (sx >= 10 && sx <= 12) ? 32'd0 : 32'd1);
            check("small vsync", 32'(s_vs), (sy == 490 || sy == 491) ? 32'd0 : 32'd1);
            check("small visible", 32'(s_vis), (sx < 8 && sy < 480) ? 32'd1 : 32'd0);
            check("small frame_start", 32'(s_fs), (c % 8400 == 0) ? 32'd1 : 32'd0);
            check("small frame", s_frame, s_frame_exp);
            if (c <= 8400 && s_vs == 1'b0) vs_low_cnt++;
            if (c == 511 * 16) begin
                $display("step y=511: position_y=%0d visible=%0d", s_y, s_vis);
                check("y511 pos", 32'(s_y), 32'd511);
                check("y511 vis", 32'(s_vis), 32'd0);
            end
            if (c == 524 * 16) begin
                $display("step y=524: position_y=%0d visible=%0d", s_y, s_vis);
                check("y524 pos", 32'(s_y), 32'd12);
                check("y524 vis", 32'(s_vis), 32'd0);
            end
            if (c == 8400) begin
                $display("step first frame boundary: x=%0d y=%0d frame=%0d", s_x, s_y, s_frame);
            end
            if (c == 8500) begin
                // Preload the frame counter just below its wrap point.
                force dut_small.frame_q = 32'hFFFF_FFFF;
                #1 release dut_small.frame_q;
                s_frame_exp = 32'hFFFF_FFFF;
                $display("step frame counter preloaded to 0xFFFFFFFF");
            end
            if (c == 16800) begin
                $display("step second frame boundary: frame=%0h", s_frame);
                check("frame wrap", s_frame, 32'd0);
            end
        end
        $display("step line: hsync low %0d cycles; frame: vsync low %0d cycles", hs_low_cnt, vs_low_cnt);
        check("hsync width", 32'(hs_low_cnt), 32'd96);
        check("vsync width", 32'(vs_low_cnt), 32'd32);
        check("full frame no early wrap", f_frame, 32'd0);

        // ---------------- asynchronous reset mid-operation ----------------
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("step async reset between edges");
        check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        $display("step first edge after reset: x=%0d fs=%0d", f_x, f_fs);
        check("post-reset full x", 32'(f_x), 32'd1);
        check("post-reset full fs", 32'(f_fs), 32'd0);
        check("post-reset small x", 32'(s_x), 32'd1);

`ifdef VGA_TIMING_PIXEL_CE_EN
        // ---------------- clock enable: 1010... ----------------
        // Restart from reset so the expected advance count starts at zero.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < 1600; i++) begin
            pixel_ce = ((i % 2) == 0);
            @(posedge clk);
            @(negedge clk);
            check("ce x", 32'(f_x), 32'(((i / 2) + 1) % 800));
            check("ce x_next", 32'(f_xn), 32'(((i / 2) + 2) % 800));
        end
        $display("step ce: after 1600 clk x=%0d y=%0d", f_x, f_y);
        check("ce line x", 32'(f_x), 32'd0);
        check("ce line y", 32'(f_y), 32'd1);
        pixel_ce = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_timing.md
Name: vga_timing

Overview:
- Raster timing generator for the screensaver display path; sits directly upstream of the image generator.
- Produces the current and one-pixel-lookahead (NEXT) raster coordinates, a frame counter, and sync/visible strobes.
- Outputs are aligned so that a downstream stage can register colour from the NEXT coordinates. Its registered colour is then valid in the same cycle as position_x/position_y, hsync, vsync and visible.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, active level of hsync (0 = active-low)
- VSYNC_POL, 0, active level of vsync

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- position_x  output  10  current horizontal count
- position_x_NEXT  output  10  horizontal count one pixel ahead
- position_y  output  9  current vertical count, low 9 bits
- position_y_NEXT  output  9  vertical count one pixel ahead, low 9 bits
- frame  output  32  completed-frame counter
- frame_start  output  1  high for the single cycle at position (0,0)
- visible  output  1  current position lies in the active area
- hsync  output  1  horizontal sync
- vsync  output  1  vertical sync

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Totals: H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
- Internal state: 10-bit h_cnt, 10-bit v_cnt, 32-bit frame, plus registered hsync, vsync, visible and frame_start.
- NEXT computation (combinational from state):
  - h_next = (h_cnt == H_TOTAL-1) ? 0 : h_cnt+1.
  - v_next increments only when h_cnt == H_TOTAL-1, and wraps from V_TOTAL-1 to 0.
  - position_x_NEXT = h_next; position_y_NEXT = v_next[8:0].
- Each clk edge:
  - h_cnt <= h_next; v_cnt <= v_next.
  - The strobes are registered from decodes of (h_next, v_next), so they describe the current position:
    - visible <= h_next < H_ACTIVE && v_next < V_ACTIVE.
    - hsync <= HSYNC_POL when H_ACTIVE+H_FRONT <= h_next < H_ACTIVE+H_FRONT+H_SYNC, else ~HSYNC_POL.
    - vsync: same form as hsync, applied to v_next with the V parameters and VSYNC_POL.
    - frame_start <= (h_next==0 && v_next==0).
- Frame counter: increments on the edge where state goes from (H_TOTAL-1, V_TOTAL-1) to (0,0). Wraps modulo 2^32, no saturation.
- Position outputs: position_x = h_cnt; position_y = v_cnt[8:0].
  - Truncation of y is intentional: it is valid only while visible = 1.
  - Consumers must gate colour with visible.
- Reset values:
  - h_cnt = 0, v_cnt = 0, frame = 0.
  - visible = 1, frame_start = 1.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - Hence position_x_NEXT = 1 and position_y_NEXT = 0 during reset.
- Reset mid-frame: all state returns to the reset values immediately (asynchronous). The first edge after deassertion advances to (1,0).
- Vsync edges coincide with the line boundary: they change on the edge where h_cnt wraps.
- No backpressure and no stall: the counter advances every cycle.

Optional Feature:
- Macro: VGA_TIMING_PIXEL_CE_EN.
- Defined:
  - Adds input port pixel_ce (1 bit), placed after rst_n.
  - All state (counters, frame, registered strobes) updates only on edges where pixel_ce = 1; otherwise everything holds.
  - NEXT outputs remain the combinational lookahead of the held state.
  - This allows operation from a 50 MHz clk with a /2 enable.
- Undefined: no pixel_ce port; the block advances on every clk edge.

Test Plan:
- Reset: hold rst_n = 0, then release. During reset expect x = 0, y = 0, x_NEXT = 1, frame = 0, visible = 1, frame_start = 1, hsync = vsync = 1. One edge after release expect x = 1 and frame_start = 0.
- Line timing:
  - hsync = 0 exactly for x in 656..751 (96 cycles).
  - visible = 0 for x ≥ 640.
  - x goes 799 → 0 while y increments by 1.
  - x_NEXT equals x one cycle later across the wrap.
- Frame timing: vsync = 0 exactly for y in 490..491 (1600 cycles). After 420000 cycles from reset, x = 0, y = 0, frame = 1, frame_start = 1 for one cycle. At v_cnt = 511 and v_cnt = 524, position_y reads 9'd511 and 9'd12 respectively, and visible = 0 at both.
- Wrap: force frame to 0xFFFFFFFF (or run with a reduced-timing parameter set). At the next frame boundary, frame = 0.
- Reset mid-operation: assert rst_n = 0 at x = 300, y = 200, asynchronously between edges. Outputs must return to the reset values before the next edge.
- VGA_TIMING_PIXEL_CE_EN: drive pixel_ce = 1010…. Counters must advance once per two clk cycles, one line must take 1600 clk, and state must hold while pixel_ce = 0.
